// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// default reply bytes sent back over the UART once the header/image is handled.
package program_loader_pkg;

    typedef enum logic [2:0] {
        StHdr,
        StLoad,
        StSend,
        StDone,
        StError
    } state_e;

    localparam logic [7:0] DefAckByte  = 8'hAA;
    localparam logic [7:0] DefNackByte = 8'h55;

endpackage

// File: rtl/program_loader_byte_to_word_packer.sv
// Byte-to-word packer: gathers little-endian bytes into 32-bit words.
// Ports:
//   clk, rstn   clock and asynchronous active-low reset
//   byte_valid  accept byte_data on this edge
//   byte_data   incoming byte
//   word_valid  combinational pulse: this byte completes a word
//   word        assembled word {byte_data, three buffered bytes}
module program_loader_byte_to_word_packer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q;
    logic [23:0] buf_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q <= 2'd0;
            buf_q <= 24'd0;
        end else if (byte_valid) begin
            idx_q <= idx_q + 2'd1;
            // Shift right so that after three bytes buf_q = {b2, b1, b0}.
            buf_q <= {byte_data, buf_q[23:8]};
        end
    end

    // The 4th byte is used directly so the word is ready on the same edge.
    assign word_valid = byte_valid && (idx_q == 2'd3);
    assign word       = {byte_data, buf_q};

endmodule

// File: rtl/program_loader.sv
// Program loader: receives a program image over UART (4-byte word count, then
// N little-endian words), stores it in a flat instruction image, holds the core
// in reset until loading completes and answers with an ACK or NACK byte.
// Ports:
//   clk, rstn            clock and asynchronous active-low reset
//   rx_valid, rx_data    received byte strobe and data
//   tx_ready             transmitter can accept a byte
//   tx_valid, tx_data    reply byte, held until tx_ready
//   imem_image           word i at bits [32i+31:32i]
//   core_rstn            core reset, released in DONE
//   load_done            high in DONE
//   load_error           high in ERROR
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 32,
    parameter int unsigned CNT_W      = 6,
    parameter logic [7:0]  ACK_BYTE   = DefAckByte,
    parameter logic [7:0]  NACK_BYTE  = DefNackByte
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    output logic [32*IMEM_DEPTH-1:0] imem_image,
    output logic                    core_rstn,
    output logic                    load_done,
    output logic                    load_error
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hdr_q, hdr_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               wr_en;
    logic               byte_accept;
    logic               word_valid;
    logic [31:0]        word;

    // Bytes arriving in SEND/DONE/ERROR never touch the packer.
    assign byte_accept = rx_valid && ((state_q == StHdr) || (state_q == StLoad));

    program_loader_byte_to_word_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .byte_valid (byte_accept),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hdr_d     = hdr_q;
        tx_data_d = tx_data_q;
        wr_en     = 1'b0;
        unique case (state_q)
            StHdr: begin
                if (word_valid) begin
                    hdr_d = word;
                    if (word == 32'd0) begin
                        state_d   = StSend;
                        tx_data_d = ACK_BYTE;
                    end else if (word > IMEM_DEPTH) begin
                        state_d   = StSend;
                        tx_data_d = NACK_BYTE;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (word_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((32'(cnt_q) + 32'd1) == hdr_q) begin
                        state_d   = StSend;
                        tx_data_d = ACK_BYTE;
                    end
                end
            end
            StSend: begin
                if (tx_ready) begin
                    state_d = (tx_data_q == ACK_BYTE) ? StDone : StError;
                end
            end
            StDone:  state_d = StDone;
            StError: state_d = StError;
            default: state_d = StHdr;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StHdr;
            cnt_q     <= '0;
            hdr_q     <= 32'd0;
            tx_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            tx_data_q <= tx_data_d;
        end
    end

    for (genvar gi = 0; gi < IMEM_DEPTH; gi++) begin : g_word
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                imem_image[32*gi +: 32] <= 32'd0;
            end else if (wr_en && (cnt_q == CNT_W'(gi))) begin
                imem_image[32*gi +: 32] <= word;
            end
        end
    end

    assign tx_valid   = (state_q == StSend);
    assign tx_data    = tx_data_q;
    assign core_rstn  = (state_q == StDone);
    assign load_done  = (state_q == StDone);
    assign load_error = (state_q == StError);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a table of per-cycle vectors for the
// basic load/ACK/NACK flows, plus hand-written sequences for the long corner cases.
module tb_program_loader;

    localparam int unsigned Depth = 32;

    logic                  clk;
    logic                  rstn;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  tx_ready;
    logic                  tx_valid;
    logic [7:0]            tx_data;
    logic [32*Depth-1:0]   imem_image;
    logic                  core_rstn;
    logic                  load_done;
    logic                  load_error;

    int total = 0;
    int bad   = 0;

    program_loader #(
        .IMEM_DEPTH (Depth),
        .CNT_W      (6),
        .ACK_BYTE   (8'hAA),
        .NACK_BYTE  (8'h55)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .imem_image (imem_image),
        .core_rstn  (core_rstn),
        .load_done  (load_done),
        .load_error (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         rxv;
        logic [7:0] rxd;
        bit         txr;
        bit         etxv;
        logic [7:0] etxd;
        bit         ecr;
        bit         edone;
        bit         eerr;
        int         wi;     // image word to check, -1 for none
        logic [31:0] ew;
    } vec_t;

    vec_t vq[$];

    function automatic logic [31:0] img_word(int i);
        return imem_image[32*i +: 32];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are then sampled there too.
    task automatic step(bit rxv, logic [7:0] rxd, bit txr);
        rx_valid = rxv;
        rx_data  = rxd;
        tx_ready = txr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        tx_ready = 1'b0;
        rstn     = 1'b0;
        #3;
        rstn     = 1'b1;
    endtask

    function automatic void add_rst();
        vq.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 32'd0});
    endfunction

    function automatic void add_b(logic [7:0] b, bit etxv, logic [7:0] etxd, int wi,
                                  logic [31:0] ew);
        vq.push_back('{1'b0, 1'b1, b, 1'b0, etxv, etxd, 1'b0, 1'b0, 1'b0, wi, ew});
    endfunction

    function automatic void add_v(bit rxv, logic [7:0] rxd, bit txr, bit etxv,
                                  logic [7:0] etxd, bit ecr, bit ed, bit ee, int wi,
                                  logic [31:0] ew);
        vq.push_back('{1'b0, rxv, rxd, txr, etxv, etxd, ecr, ed, ee, wi, ew});
    endfunction

    initial begin
        logic [31:0] w;
        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        tx_ready = 1'b0;

        // Three-word load, ACK, DONE.
        add_rst();
        add_b(8'h03, 0, 8'h00, -1, 0); add_b(8'h00, 0, 8'h00, -1, 0);
        add_b(8'h00, 0, 8'h00, -1, 0); add_b(8'h00, 0, 8'h00, -1, 0);
        add_b(8'h93, 0, 8'h00, 0, 32'd0); add_b(8'h00, 0, 8'h00, 0, 32'd0);
        add_b(8'h10, 0, 8'h00, 0, 32'd0); add_b(8'h00, 0, 8'h00, 0, 32'h0010_0093);
        add_b(8'h13, 0, 8'h00, 1, 32'd0); add_b(8'h01, 0, 8'h00, -1, 0);
        add_b(8'h10, 0, 8'h00, -1, 0); add_b(8'h00, 0, 8'h00, 1, 32'h0010_0113);
        add_b(8'h13, 0, 8'h00, -1, 0); add_b(8'h02, 0, 8'h00, -1, 0);
        add_b(8'h20, 0, 8'h00, 2, 32'd0); add_b(8'h00, 1, 8'hAA, 2, 32'h0020_0213);
        add_v(0, 8'h00, 0, 1, 8'hAA, 0, 0, 0, 3, 32'd0);
        add_v(0, 8'h00, 1, 0, 8'h00, 1, 1, 0, 0, 32'h0010_0093);
        add_v(1, 8'h77, 0, 0, 8'h00, 1, 1, 0, 31, 32'd0);
        add_v(1, 8'h77, 0, 0, 8'h00, 1, 1, 0, 1, 32'h0010_0113);
        // Zero-length image: immediate ACK.
        add_rst();
        add_b(8'h00, 0, 8'h00, -1, 0); add_b(8'h00, 0, 8'h00, -1, 0);
        add_b(8'h00, 0, 8'h00, -1, 0); add_b(8'h00, 1, 8'hAA, -1, 0);
        add_v(0, 8'h00, 1, 0, 8'h00, 1, 1, 0, 0, 32'd0);
        // Count 33: NACK, ERROR, later bytes ignored.
        add_rst();
        add_b(8'h21, 0, 8'h00, -1, 0); add_b(8'h00, 0, 8'h00, -1, 0);
        add_b(8'h00, 0, 8'h00, -1, 0); add_b(8'h00, 1, 8'h55, -1, 0);
        add_v(0, 8'h00, 0, 1, 8'h55, 0, 0, 0, -1, 0);
        add_v(0, 8'h00, 1, 0, 8'h00, 0, 0, 1, -1, 0);
        for (int k = 0; k < 4; k++) add_v(1, 8'h01, 0, 0, 8'h00, 0, 0, 1, 0, 32'd0);
        // Count 0xFFFFFFFF and a count with only the top byte set: NACK.
        add_rst();
        for (int k = 0; k < 3; k++) add_b(8'hFF, 0, 8'h00, -1, 0);
        add_b(8'hFF, 1, 8'h55, -1, 0);
        add_rst();
        for (int k = 0; k < 3; k++) add_b(8'h00, 0, 8'h00, -1, 0);
        add_b(8'h01, 1, 8'h55, -1, 0);

        foreach (vq[i]) begin
            vec_t v;
            v = vq[i];
            if (v.rst) do_reset();
            else step(v.rxv, v.rxd, v.txr);
            check($sformatf("v%0d tx_valid", i), 32'(tx_valid), 32'(v.etxv));
            if (v.etxv || v.rst) check($sformatf("v%0d tx_data", i), 32'(tx_data), 32'(v.etxd));
            check($sformatf("v%0d core_rstn", i), 32'(core_rstn), 32'(v.ecr));
            check($sformatf("v%0d load_done", i), 32'(load_done), 32'(v.edone));
            check($sformatf("v%0d load_error", i), 32'(load_error), 32'(v.eerr));
            if (v.wi >= 0) check($sformatf("v%0d word%0d", i, v.wi), img_word(v.wi), v.ew);
        end

        // Full 32-word load.
        do_reset();
        step(1, 8'h20, 0); step(1, 8'h00, 0); step(1, 8'h00, 0); step(1, 8'h00, 0);
        check("full hdr tx_valid", 32'(tx_valid), 32'd0);
        for (int i = 0; i < 32; i++) begin
            w = 32'h0000_0013 | (32'(i) << 7);
            for (int k = 0; k < 4; k++) step(1, w[8*k +: 8], 0);
        end
        check("full tx_valid", 32'(tx_valid), 32'd1);
        check("full tx_data", 32'(tx_data), 32'hAA);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("full word%0d", i), img_word(i), 32'h0000_0013 | (32'(i) << 7));
        end
        step(0, 8'h00, 1);
        check("full done", 32'(load_done), 32'd1);
        check("full core_rstn", 32'(core_rstn), 32'd1);

        // Backpressure in SEND with rx traffic.
        do_reset();
        step(1, 8'h01, 0); step(1, 8'h00, 0); step(1, 8'h00, 0); step(1, 8'h00, 0);
        step(1, 8'h93, 0); step(1, 8'h00, 0); step(1, 8'h10, 0); step(1, 8'h00, 0);
        for (int c = 0; c < 50; c++) begin
            step(1'(c % 2), 8'($urandom_range(0, 255)), 0);
            check($sformatf("hold%0d tx_valid", c), 32'(tx_valid), 32'd1);
            check($sformatf("hold%0d tx_data", c), 32'(tx_data), 32'hAA);
        end
        check("hold word0", img_word(0), 32'h0010_0093);
        check("hold word1", img_word(1), 32'd0);
        check("hold core_rstn", 32'(core_rstn), 32'd0);
        check("hold done", 32'(load_done), 32'd0);
        step(0, 8'h00, 1);
        check("hold release done", 32'(load_done), 32'd1);
        check("hold release tx_valid", 32'(tx_valid), 32'd0);

        // Asynchronous reset mid-load, then a fresh one-word load.
        do_reset();
        step(1, 8'h04, 0); step(1, 8'h00, 0); step(1, 8'h00, 0); step(1, 8'h00, 0);
        step(1, 8'h44, 0); step(1, 8'h33, 0); step(1, 8'h22, 0); step(1, 8'h11, 0);
        step(1, 8'h88, 0); step(1, 8'h77, 0); step(1, 8'h66, 0); step(1, 8'h55, 0);
        check("mid word1", img_word(1), 32'h5566_7788);
        rx_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check("mid rst word0", img_word(0), 32'd0);
        check("mid rst word1", img_word(1), 32'd0);
        check("mid rst tx_valid", 32'(tx_valid), 32'd0);
        check("mid rst core_rstn", 32'(core_rstn), 32'd0);
        #2;
        rstn = 1'b1;
        step(1, 8'h01, 0); step(1, 8'h00, 0); step(1, 8'h00, 0); step(1, 8'h00, 0);
        step(1, 8'hEF, 0); step(1, 8'hBE, 0); step(1, 8'hAD, 0); step(1, 8'hDE, 0);
        check("fresh tx_data", 32'(tx_data), 32'hAA);
        step(0, 8'h00, 1);
        check("fresh done", 32'(load_done), 32'd1);
        check("fresh word0", img_word(0), 32'hDEAD_BEEF);
        check("fresh word1", img_word(1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
